// File: rtl/counter_seq_ctrl_if.sv
// Handshake/bus bundle between a requester and counter_seq_ctrl.
//   master (requester): drives start, stop, pause, up, limit; observes q, busy, tc, done
//   slave  (controller): observes the controls; drives q, busy, tc, done
interface counter_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             up;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output start, stop, pause, up, limit,
    input  q, busy, tc, done
  );

  modport slave (
    input  start, stop, pause, up, limit,
    output q, busy, tc, done
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a WIDTH-bit interval counter.
// Runs the count register from 0 up to a latched limit, or from the limit down
// to 0, with pause/resume, abort and a one-cycle done pulse.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - counter_seq_ctrl_if.slave: start/stop/pause/up/limit in,
//          q/busy/done (registered) and tc (combinational) out
// Optional feature: define COUNTER_SEQ_AUTO_RELOAD_EN to make DONE reload the
// count and re-enter RUN instead of returning to IDLE.
module counter_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  counter_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] lim_r;
  logic             dir_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] term_c;
  logic             at_term_c;

  // Terminal value depends on the direction latched at start.
  assign term_c    = dir_r ? lim_r : '0;
  assign at_term_c = (q_r == term_c);

  // State, count and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      q_r    <= '0;
      lim_r  <= '0;
      dir_r  <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            lim_r  <= bus.limit;
            dir_r  <= bus.up;
            q_r    <= bus.up ? '0 : bus.limit;
            busy_r <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          // stop beats terminal, terminal beats pause, pause beats step
          if (bus.stop) begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else if (at_term_c) begin
            done_r <= 1'b1;
            state  <= S_DONE;
          end else if (bus.pause) begin
            state  <= S_HOLD;
          end else if (dir_r) begin
            q_r <= q_r + WIDTH'(1);
          end else begin
            q_r <= q_r - WIDTH'(1);
          end
        end
        S_HOLD: begin
          // Resuming does not step on the resume edge.
          if (bus.stop) begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else if (!bus.pause) begin
            state  <= S_RUN;
          end
        end
        S_DONE: begin
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
          q_r   <= dir_r ? '0 : lim_r;
          state <= S_RUN;
`else
          busy_r <= 1'b0;
          state  <= S_IDLE;
`endif
        end
        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.q    = q_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.tc   = (state == S_RUN) && at_term_c;

endmodule
